bcd_sseg_scan: RTL and testbench
================================

# bcd_sseg_scan

Two-digit multiplexed seven-segment scan driver that sits directly downstream of the binary-to-BCD converter. It captures the converter's 8-bit packed BCD result on a load strobe and time-multiplexes the two digits onto a common-anode display with inter-digit blanking. New values are committed only at frame boundaries, so the display never tears. It also supports leading-zero blanking and flags invalid nibbles.

## Interface
- REFRESH_DIV, 100000, clock cycles each digit is lit (≥2)
- BLANK_CYC, 16, clock cycles all anodes are off between digits (≥1)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- bcd_in  in  8  packed BCD from the converter: [7:4] tens, [3:0] units
- load  in  1  single-cycle strobe; bcd_in and blank_lz are sampled when high
- blank_lz  in  1  leading-zero blank request, sampled with load
- seg_n  out  7  active-low segments {g,f,e,d,c,b,a}
- an_n  out  2  active-low anodes: [0] units, [1] tens
- err  out  1  high while the committed value holds a nibble >9

## Operation
- Registers:
  - shadow (8b + blank flag), written on every load
  - active (8b + blank flag), displayed value
  - pending flag
  - FSM state
  - counter, width $clog2(max(REFRESH_DIV,BLANK_CYC))
- FSM states: OFF, DIG0, GAP0, DIG1, GAP1.
- OFF: all outputs dark. On load: active←bcd_in, then go to DIG0 with cnt=0.
- DIG*: hold for REFRESH_DIV cycles (cnt 0..REFRESH_DIV-1), then go to the next GAP with cnt=0.
- GAP*: hold for BLANK_CYC cycles, then go to the next DIG. Sequence is DIG0→GAP0→DIG1→GAP1→DIG0.
- Load while scanning: shadow←bcd_in and pending←1. Multiple loads before commit: last wins.
- Commit happens on the GAP1→DIG0 transition only: active←shadow, pending←0.
- Load in the same cycle as the GAP1→DIG0 transition: bcd_in bypasses to active directly, and pending stays 0.
- DIG0 drives an_n=2'b10, seg_n=decode(active[3:0]).
- DIG1 drives an_n=2'b01, seg_n=decode(active[7:4]).
  - Exception: if the blank flag is set and tens==0, DIG1 instead drives an_n=2'b11, seg_n=7'h7F.
- GAP* and OFF drive an_n=2'b11, seg_n=7'h7F.
- Decode, 0..9: 40,79,24,30,19,12,02,78,00,10 (hex). Nibbles A–F decode to dash 7'h3F.
- err = (active[3:0]>9) | (active[7:4]>9). It updates with active.
- Leading-zero blanking never blanks the units digit; 0x00 displays "0".
- Once started, there is no return to OFF except by rst.

## Timing
- All outputs are registered. Each output changes on the same edge as the state change that selects it.
- Reset values: seg_n=7'h7F, an_n=2'b11, err=0, state=OFF, cnt=0, shadow=active=0, pending=0.
- rst assertion forces reset values immediately, asynchronously, including mid-digit. The block remains in OFF until the first load after rst deasserts.
- First load latency: load high in cycle t gives an_n=2'b10 from the edge ending cycle t.
- Frame period: 2·(REFRESH_DIV+BLANK_CYC) cycles. Each anode is low for exactly REFRESH_DIV consecutive cycles per frame.
- Worst-case load-to-display latency: one frame plus one cycle.
- The two anodes are never low simultaneously. At least BLANK_CYC dark cycles separate them.
- load is ignored during rst.

## Structure
- Package sseg_pkg contains:
  - state enum (OFF, DIG0, GAP0, DIG1, GAP1)
  - constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F
  - the ten-entry digit segment table
- Sub-module seg7_decode: combinational 4-bit → 7-bit active-low decode, with A–F mapped to dash. It is instantiated once; its input is muxed by state.
- All registers reside in the top-level bcd_sseg_scan.

## Test plan
Bench parameters: REFRESH_DIV=4, BLANK_CYC=2.
- Reset, then load 0x42 with blank_lz=0 → 4 cycles an_n=10/seg_n=0x24, 2 cycles 11/0x7F, 4 cycles 01/0x19, 2 cycles 11/0x7F; pattern repeats with period 12.
- Load 0x42, then load 0x17 during the first DIG1 → tens stays 0x19 until the frame ends; the next DIG0 shows 0x78 and DIG1 shows 0x79.
- Load 0x07 with blank_lz=1 → DIG0 shows 0x78; DIG1 keeps an_n=11 and seg_n=0x7F. Load 0x00 with blank_lz=1 → units shows 0x40.
- Load 0xA3 → err=1 from commit; DIG1 seg_n=0x3F, DIG0 0x30. Load 0x55 → err=0 at the next commit.
- Load asserted exactly on the GAP1→DIG0 cycle with 0x98 → that DIG0 shows 0x00, and the following DIG1 shows 0x10.
- Assert rst mid-DIG1 → same-cycle an_n=11, seg_n=7'h7F, err=0. After release, with no load, outputs stay dark for more than 3 frames.

Source files
------------

// File: rtl/sseg_pkg.sv
// sseg_pkg: shared definitions for the two-digit seven-segment scan driver.
//   scan_state_t : scan FSM states
//   SEG_BLANK    : all segments off (active-low)
//   SEG_DASH     : middle bar only, shown for non-decimal nibbles
//   DIGIT_SEG    : active-low {g,f,e,d,c,b,a} patterns for digits 0..9
package sseg_pkg;

  typedef enum logic [2:0] {
    OFF,
    DIG0,
    GAP0,
    DIG1,
    GAP1
  } scan_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Entry [n] is the pattern for digit n (listed from 9 down to 0).
  localparam logic [9:0][6:0] DIGIT_SEG = {
    7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
    7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/bcd_sseg_scan_if.sv
// bcd_sseg_scan_if: bundle between the BCD converter side and the scan driver.
//   bcd_in   : packed BCD value, [7:4] tens, [3:0] units
//   load     : single-cycle strobe qualifying bcd_in and blank_lz
//   blank_lz : leading-zero blank request
//   seg_n    : active-low segments {g,f,e,d,c,b,a}
//   an_n     : active-low anodes, [0] units, [1] tens
//   err      : committed value holds a nibble above 9
// master drives the value and strobe; slave is the scan driver.
interface bcd_sseg_scan_if;

  logic [7:0] bcd_in;
  logic       load;
  logic       blank_lz;
  logic [6:0] seg_n;
  logic [1:0] an_n;
  logic       err;

  modport master (
    output bcd_in, load, blank_lz,
    input  seg_n, an_n, err
  );

  modport slave (
    input  bcd_in, load, blank_lz,
    output seg_n, an_n, err
  );

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational 4-bit to active-low seven-segment decode.
//   digit : nibble to show
//   seg_n : active-low {g,f,e,d,c,b,a}; nibbles A-F show a dash
module seg7_decode
  import sseg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_DASH;
    if (digit <= 4'd9) begin
      seg_n = DIGIT_SEG[digit];
    end
  end

endmodule

// File: rtl/bcd_sseg_scan.sv
// bcd_sseg_scan: two-digit multiplexed common-anode seven-segment scan driver.
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : slave side of bcd_sseg_scan_if (bcd_in/load/blank_lz in,
//         seg_n/an_n/err out, all outputs registered)
// Each digit is lit for REFRESH_DIV cycles with BLANK_CYC dark cycles after
// it. Loads arriving while scanning wait in a shadow register and are only
// committed at the frame boundary so a frame never mixes two values.
module bcd_sseg_scan
  import sseg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input logic           clk,
  input logic           rst,
  bcd_sseg_scan_if.slave bus
);

  localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(BLANK_CYC - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       shadow, shadow_nxt;
  logic             shadow_blank, shadow_blank_nxt;
  logic [7:0]       active, active_nxt;
  logic             active_blank, active_blank_nxt;
  logic             pending, pending_nxt;
  logic [6:0]       seg_q, seg_nxt;
  logic [1:0]       an_q, an_nxt;
  logic             err_q, err_nxt;
  logic             cnt_done;
  logic [3:0]       dec_in;
  logic [6:0]       dec_out;

  // All state and the registered outputs; reset darkens the display at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= OFF;
      cnt          <= '0;
      shadow       <= '0;
      shadow_blank <= 1'b0;
      active       <= '0;
      active_blank <= 1'b0;
      pending      <= 1'b0;
      seg_q        <= SEG_BLANK;
      an_q         <= 2'b11;
      err_q        <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      shadow       <= shadow_nxt;
      shadow_blank <= shadow_blank_nxt;
      active       <= active_nxt;
      active_blank <= active_blank_nxt;
      pending      <= pending_nxt;
      seg_q        <= seg_nxt;
      an_q         <= an_nxt;
      err_q        <= err_nxt;
    end
  end

  // Next-state logic. A load on the GAP1->DIG0 edge goes straight to active,
  // otherwise a scanning load only updates shadow and raises pending.
  always_comb begin
    state_nxt        = state;
    cnt_nxt          = cnt;
    shadow_nxt       = shadow;
    shadow_blank_nxt = shadow_blank;
    active_nxt       = active;
    active_blank_nxt = active_blank;
    pending_nxt      = pending;
    cnt_done         = 1'b0;

    if (bus.load) begin
      shadow_nxt       = bus.bcd_in;
      shadow_blank_nxt = bus.blank_lz;
    end

    if (state == OFF) begin
      if (bus.load) begin
        active_nxt       = bus.bcd_in;
        active_blank_nxt = bus.blank_lz;
        state_nxt        = DIG0;
        cnt_nxt          = '0;
      end
    end else begin
      cnt_done = (state == DIG0 || state == DIG1) ? (cnt == DIG_LAST)
                                                  : (cnt == GAP_LAST);
      if (bus.load) begin
        pending_nxt = 1'b1;
      end
      if (cnt_done) begin
        cnt_nxt = '0;
        unique case (state)
          DIG0:    state_nxt = GAP0;
          GAP0:    state_nxt = DIG1;
          DIG1:    state_nxt = GAP1;
          default: state_nxt = DIG0;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
      if (state == GAP1 && cnt_done) begin
        pending_nxt = 1'b0;
        if (bus.load) begin
          active_nxt       = bus.bcd_in;
          active_blank_nxt = bus.blank_lz;
        end else if (pending) begin
          active_nxt       = shadow;
          active_blank_nxt = shadow_blank;
        end
      end
    end
  end

  // The single decoder looks at whichever digit the next state will light.
  assign dec_in = (state_nxt == DIG1) ? active_nxt[7:4] : active_nxt[3:0];

  seg7_decode u_dec (
    .digit (dec_in),
    .seg_n (dec_out)
  );

  // Output selection from the next state so outputs move with the state.
  // The tens digit stays dark when blanking is requested and it is zero.
  always_comb begin
    an_nxt  = 2'b11;
    seg_nxt = SEG_BLANK;
    err_nxt = (active_nxt[3:0] > 4'd9) | (active_nxt[7:4] > 4'd9);
    if (state_nxt == DIG0) begin
      an_nxt  = 2'b10;
      seg_nxt = dec_out;
    end else if (state_nxt == DIG1) begin
      if (!(active_blank_nxt && active_nxt[7:4] == 4'd0)) begin
        an_nxt  = 2'b01;
        seg_nxt = dec_out;
      end
    end
  end

  assign bus.seg_n = seg_q;
  assign bus.an_n  = an_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_bcd_sseg_scan.sv
// tb_bcd_sseg_scan: scoreboard bench for bcd_sseg_scan with REFRESH_DIV=4,
// BLANK_CYC=2 (frame = 12 cycles). Expected outputs are queued per cycle
// number; a negedge monitor pops and compares whatever is due.
module tb_bcd_sseg_scan;

  typedef struct {
    int         cyc;
    int         step;
    logic [1:0] an;
    logic [6:0] seg;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t sb_q[$];
  exp_t mon_e;

  bcd_sseg_scan_if bus();

  bcd_sseg_scan #(
    .REFRESH_DIV (4),
    .BLANK_CYC   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock and a cycle counter that names each clock period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Queue one expected output for a given cycle.
  task automatic pushExp(input int step, input int c, input logic [1:0] an,
                         input logic [6:0] seg, input logic e);
    exp_t x;
    x.cyc  = c;
    x.step = step;
    x.an   = an;
    x.seg  = seg;
    x.err  = e;
    sb_q.push_back(x);
  endtask

  // Queue n cycles of one 12-cycle frame starting at base.
  task automatic pushFrame(input int step, input int base, input logic [6:0] useg,
                           input logic [1:0] tan, input logic [6:0] tseg,
                           input logic e, input int n);
    for (int i = 0; i < n; i++) begin
      if (i < 4)       pushExp(step, base + i, 2'b10, useg, e);
      else if (i < 6)  pushExp(step, base + i, 2'b11, 7'h7F, e);
      else if (i < 10) pushExp(step, base + i, tan, tseg, e);
      else             pushExp(step, base + i, 2'b11, 7'h7F, e);
    end
  endtask

  // Queue dark display for cycles first..last.
  task automatic pushDark(input int step, input int first, input int last,
                          input logic e);
    for (int c = first; c <= last; c++) pushExp(step, c, 2'b11, 7'h7F, e);
  endtask

  // Hold load high during cycle c, so it is sampled at the edge ending c.
  task automatic applyStimulus(input int c, input logic [7:0] v, input logic blz);
    if (cyc >= c) begin
      total++;
      bad++;
      $display("[TB] FAIL late_load: now cyc=%0d, required before cyc=%0d", cyc, c);
    end
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
    bus.bcd_in   = v;
    bus.blank_lz = blz;
    bus.load     = 1'b1;
    @(posedge clk);
    #1;
    bus.load     = 1'b0;
  endtask

  // Compare one scoreboard entry against the DUT outputs.
  task automatic checkOutput(input exp_t x);
    total++;
    if (x.cyc != cyc || bus.an_n !== x.an || bus.seg_n !== x.seg ||
        bus.err !== x.err) begin
      bad++;
      $display("[TB] FAIL step%0d cyc=%0d (due %0d): got an_n=%b seg_n=%h err=%b, expected an_n=%b seg_n=%h err=%b",
               x.step, cyc, x.cyc, bus.an_n, bus.seg_n, bus.err, x.an, x.seg, x.err);
    end
  endtask

  // Monitor: every falling edge, compare all entries that have come due.
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      checkOutput(mon_e);
    end
  end

  // Expected schedule, then the directed stimulus that produces it.
  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b0;
    bus.bcd_in   = 8'h00;
    bus.load     = 1'b0;
    bus.blank_lz = 1'b0;

    pushDark(0, 1, 5, 1'b0);
    pushFrame(1, 6,  7'h24, 2'b01, 7'h19, 1'b0, 12);
    pushFrame(2, 18, 7'h78, 2'b01, 7'h79, 1'b0, 12);
    pushFrame(3, 30, 7'h78, 2'b11, 7'h7F, 1'b0, 12);
    pushFrame(4, 42, 7'h40, 2'b11, 7'h7F, 1'b0, 12);
    pushFrame(5, 54, 7'h30, 2'b01, 7'h3F, 1'b1, 12);
    pushFrame(6, 66, 7'h12, 2'b01, 7'h12, 1'b0, 12);
    pushFrame(7, 78, 7'h00, 2'b01, 7'h10, 1'b0, 12);
    pushFrame(8, 90, 7'h00, 2'b01, 7'h10, 1'b0, 12);
    pushFrame(9, 102, 7'h40, 2'b01, 7'h3F, 1'b1, 7);
    pushDark(10, 109, 160, 1'b0);

    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    applyStimulus(5,  8'h42, 1'b0);
    applyStimulus(12, 8'h17, 1'b0);
    applyStimulus(20, 8'h99, 1'b0);
    applyStimulus(23, 8'h07, 1'b1);
    applyStimulus(32, 8'h00, 1'b1);
    applyStimulus(44, 8'hA3, 1'b0);
    applyStimulus(56, 8'h55, 1'b0);
    applyStimulus(70, 8'h11, 1'b0);
    applyStimulus(77, 8'h98, 1'b0);
    applyStimulus(95, 8'hB0, 1'b0);

    while (cyc < 109) begin
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b1;
    applyStimulus(110, 8'h33, 1'b0);
    while (cyc < 112) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;

    for (int g = 0; g < 300 && sb_q.size() > 0; g++) @(posedge clk);
    @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: %0d entries left, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #100000;
    total++;
    bad++;
    $display("[TB] FAIL timeout: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
